// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU (AND/OR/ADD/SUB/SLT/SLL/SRL) with an
// optional iterative shift-add unsigned multiply (MULTU).
//
// Build option: define ALU_MUL_EN to include the multiplier, CALC state and
// step counter. Without it MULTU decodes as an unsupported code and hiOut
// stays 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request valid            in_ready  unit can accept this cycle
//   dataA      operand A                dataB     operand B / shift amount
//   Signal     6-bit funct code
//   out_valid  result valid             out_ready consumer takes result
//   dataOut    result (MULTU: low half) hiOut     MULTU high half, else 0
//   zero       dataOut == 0             overflow  signed overflow (ADD/SUB)
//   err        unsupported funct code
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hiOut,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
`ifdef ALU_MUL_EN
    localparam logic [5:0] F_MULTU = 6'd25;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
`ifdef ALU_MUL_EN
    localparam logic [1:0] S_CALC = 2'd2;
    localparam int unsigned CNT_W = $clog2(WIDTH);
`endif

    logic [1:0]       state, state_d;
    logic             valid_d, zero_d, ovf_d, err_d;
    logic [WIDTH-1:0] data_d, hi_d, hi_q;
    logic             accept;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             add_ovf, sub_ovf, alu_ovf, alu_err;

`ifdef ALU_MUL_EN
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2*WIDTH-1:0] prod, prod_d, prod_step;
    logic [WIDTH-1:0]   mcand, mcand_d;
    logic [WIDTH:0]     mul_sum;
    logic               is_mul;
`endif

    // Handshake: accept in IDLE, or in DONE when the held result drains now.
    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign hiOut    = hi_q;

    // Single-cycle datapath.
    always_comb begin
        sum     = dataA + dataB;
        diff    = dataA - dataB;
        add_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
        sub_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff[WIDTH-1] != dataA[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (Signal)
            F_AND: alu_res = dataA & dataB;
            F_OR:  alu_res = dataA | dataB;
            F_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            F_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            // Sign of the difference corrected by overflow gives the true signed compare.
            F_SLT: alu_res = WIDTH'(diff[WIDTH-1] ^ sub_ovf);
            F_SLL: alu_res = dataA << dataB[SH_W-1:0];
            F_SRL: alu_res = dataA >> dataB[SH_W-1:0];
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // One shift-add step: add multiplicand into the high half if the current
    // multiplier bit is set, then shift the whole product right by one.
    always_comb begin
        is_mul    = (Signal == F_MULTU);
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step = {mul_sum, prod[WIDTH-1:1]};
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state;
        valid_d = out_valid;
        data_d  = dataOut;
        hi_d    = hi_q;
        zero_d  = zero;
        ovf_d   = overflow;
        err_d   = err;
`ifdef ALU_MUL_EN
        cnt_d   = cnt;
        prod_d  = prod;
        mcand_d = mcand;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if ((state == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    hi_d    = '0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, dataB};
                        mcand_d = dataA;
                        valid_d = 1'b0;
                        data_d  = '0;
                        hi_d    = '0;
                        zero_d  = 1'b0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                    end else
`endif
                    begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        data_d  = alu_res;
                        hi_d    = '0;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        err_d   = alu_err;
                    end
                end
            end
`ifdef ALU_MUL_EN
            S_CALC: begin
                prod_d = prod_step;
                cnt_d  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    data_d  = prod_step[WIDTH-1:0];
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_step[WIDTH-1:0] == '0);
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            dataOut   <= '0;
            hi_q      <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            out_valid <= valid_d;
            dataOut   <= data_d;
            hi_q      <= hi_d;
            zero      <= zero_d;
            overflow  <= ovf_d;
            err       <= err_d;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier working registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
        end else begin
            cnt   <= cnt_d;
            prod  <= prod_d;
            mcand <= mcand_d;
        end
    end
`endif

endmodule
